// File: rtl/b10_downcounter_pkg.sv
// Shared definitions for the BCD countdown timer: FSM state encoding,
// BCD digit limit and the load-time digit clamp.
package b10_downcounter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Non-BCD nibbles (A-F) saturate to 9 so the counter never holds an illegal digit.
    function automatic logic [3:0] clamp_digit(input logic [3:0] x);
        return (x > BCD_MAX) ? BCD_MAX : x;
    endfunction

endpackage

// File: rtl/b10_halfsubtractor.sv
// Single BCD digit decrementer: subtracts the borrow-in, wrapping 0 to 9
// and raising borrow-out when it does.
module b10_halfsubtractor
    import b10_downcounter_pkg::*;
(
    input  logic [3:0] x3_x0,
    input  logic       bin,
    output logic [3:0] d3_d0,
    output logic       bout
);

    always_comb begin
        d3_d0 = x3_x0;
        bout  = 1'b0;
        if (bin) begin
            if (x3_x0 == 4'd0) begin
                d3_d0 = BCD_MAX;
                bout  = 1'b1;
            end else begin
                d3_d0 = x3_x0 - 4'd1;
            end
        end
    end

endmodule

// File: rtl/b10_downcounter.sv
// Multi-digit BCD countdown timer with parallel load and an IDLE/RUN/DONE
// control FSM; flags expiry with a single-cycle pulse on reaching zero.
module b10_downcounter
    import b10_downcounter_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   d,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   q,
    output logic                  running,
    output logic                  expired,
    output logic                  zero
);

    localparam logic [4*DIGITS-1:0] COUNT_ONE = {{(4*DIGITS-1){1'b0}}, 1'b1};

    state_t                state;
    state_t                state_next;
    logic [4*DIGITS-1:0]   q_next;
    logic [4*DIGITS-1:0]   q_dec;
    logic [4*DIGITS-1:0]   d_clamped;
    logic [DIGITS:0]       borrow;
    logic                  expired_next;

    assign zero      = (q == '0);
    assign borrow[0] = (state == RUN) && tick && !stop;

    // Borrow ripples upward: a digit only moves when every digit below it is zero.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        b10_halfsubtractor u_digit (
            .x3_x0 (q[4*i +: 4]),
            .bin   (borrow[i]),
            .d3_d0 (q_dec[4*i +: 4]),
            .bout  (borrow[i+1])
        );
    end

    always_comb begin
        d_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d_clamped[4*i +: 4] = clamp_digit(d[4*i +: 4]);
        end
    end

    always_comb begin
        state_next   = state;
        q_next       = q;
        expired_next = 1'b0;
        if (load) begin
            q_next     = d_clamped;
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!stop && start) begin
                        if (zero) begin
                            state_next   = DONE;
                            expired_next = 1'b1;
                        end else begin
                            state_next = RUN;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_next = IDLE;
                    end else if (tick && !borrow[DIGITS]) begin
                        // A borrow out of the top digit would mean wrapping 0 to all-9s; refuse it.
                        q_next = q_dec;
                        if (q == COUNT_ONE) begin
                            state_next   = DONE;
                            expired_next = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q       <= '0;
            state   <= IDLE;
            running <= 1'b0;
            expired <= 1'b0;
        end else begin
            q       <= q_next;
            state   <= state_next;
            running <= (state_next == RUN);
            expired <= expired_next;
        end
    end

endmodule

// File: tb/tb_b10_downcounter.sv
// Directed bench for the BCD countdown timer: a vector table for the main
// sequences plus hand-written reset, borrow and full-countdown scenarios.
module tb_b10_downcounter;

    localparam int DIGITS = 4;
    localparam int W = 4 * DIGITS;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         load  = 1'b0;
    logic [W-1:0] d     = '0;
    logic         start = 1'b0;
    logic         stop  = 1'b0;
    logic         tick  = 1'b0;
    logic [W-1:0] q;
    logic         running;
    logic         expired;
    logic         zero;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic         ld;
        logic [W-1:0] din;
        logic         st;
        logic         sp;
        logic         tk;
        logic [W-1:0] exp_q;
        logic         exp_run;
        logic         exp_exp;
    } vec_t;

    vec_t vecs[32];

    b10_downcounter #(.DIGITS(DIGITS)) dut (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .d       (d),
        .start   (start),
        .stop    (stop),
        .tick    (tick),
        .q       (q),
        .running (running),
        .expired (expired),
        .zero    (zero)
    );

    always #5 clock = ~clock;

    // Drive one cycle of inputs, clock them in, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic rst, input logic ld, input logic [W-1:0] din,
                                 input logic st, input logic sp, input logic tk);
        reset = rst;
        load  = ld;
        d     = din;
        start = st;
        stop  = sp;
        tick  = tk;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] exp_q,
                               input logic exp_run, input logic exp_exp);
        logic exp_zero;
        exp_zero = (exp_q == '0);
        compared++;
        if (q !== exp_q) begin
            mismatched++;
            $display("[TB] FAIL %s q: got %h want %h", name, q, exp_q);
        end
        compared++;
        if (running !== exp_run) begin
            mismatched++;
            $display("[TB] FAIL %s running: got %b want %b", name, running, exp_run);
        end
        compared++;
        if (expired !== exp_exp) begin
            mismatched++;
            $display("[TB] FAIL %s expired: got %b want %b", name, expired, exp_exp);
        end
        compared++;
        if (zero !== exp_zero) begin
            mismatched++;
            $display("[TB] FAIL %s zero: got %b want %b", name, zero, exp_zero);
        end
    endtask

    initial begin
        //          ld    din       st    sp    tk    q         run   exp
        vecs[0]  = '{1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1000, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0999, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0998, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0010, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0009, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0008, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0007, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0007, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0007, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0006, 1'b1, 1'b0};
        vecs[20] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0};
        vecs[21] = '{1'b1, 16'h0A0F, 1'b0, 1'b0, 1'b0, 16'h0909, 1'b0, 1'b0};
        vecs[22] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[23] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[24] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[25] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[26] = '{1'b1, 16'h0020, 1'b0, 1'b0, 1'b0, 16'h0020, 1'b0, 1'b0};
        vecs[27] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0020, 1'b1, 1'b0};
        vecs[28] = '{1'b1, 16'h0050, 1'b1, 1'b0, 1'b1, 16'h0050, 1'b0, 1'b0};
        vecs[29] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0050, 1'b1, 1'b0};
        vecs[30] = '{1'b1, 16'h0033, 1'b0, 1'b1, 1'b0, 16'h0033, 1'b0, 1'b0};
        vecs[31] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0033, 1'b0, 1'b0};

        $display("[TB] reset check");
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset", 16'h0000, 1'b0, 1'b0);

        $display("[TB] vector table");
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, vecs[i].ld, vecs[i].din, vecs[i].st, vecs[i].sp, vecs[i].tk);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_run, vecs[i].exp_exp);
        end

        $display("[TB] reset mid-count");
        applyStimulus(1'b0, 1'b1, 16'h0042, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("run_at_42", 16'h0042, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h0077, 1'b1, 1'b0, 1'b1);
        checkOutput("reset_mid", 16'h0000, 1'b0, 1'b0);

        $display("[TB] multi-digit borrow");
        applyStimulus(1'b0, 1'b1, 16'h9000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        checkOutput("start_no_tick", 16'h9000, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("borrow_9000", 16'h8999, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("hold_no_tick", 16'h8999, 1'b1, 1'b0);

        // Full countdown from 12: expired must pulse exactly once, on the edge reaching zero.
        $display("[TB] full countdown from 12");
        applyStimulus(1'b0, 1'b1, 16'h0012, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        begin
            int model;
            logic [W-1:0] model_bcd;
            model = 12;
            for (int k = 0; k < 14; k++) begin
                applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
                if (model > 0) model = model - 1;
                model_bcd = W'(((model / 10) << 4) | (model % 10));
                checkOutput($sformatf("count%0d", k), model_bcd,
                            (model != 0), (k == 11));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
